// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 5-stage pipeline. It produces
// registered forwarding selects for the EX-stage ALU operand muxes, and
// combinational pipeline-register write enables and flushes for load-use
// stalls, taken-branch flushes and multi-cycle mul/div occupancy of EX.
//
// Parameters
//   MD_LAT        total EX-stage occupancy of a mul/div op in cycles (2..15)
//   RA_W          register-address width
// Ports
//   clk, rst      clock and synchronous active-high reset
//   id_rs/id_rt   source registers of the ID instruction
//   id_use_rs/rt  ID instruction actually reads rs / rt
//   ex_rd, ex_regwrite, ex_memread   destination, writeback and load flag in EX
//   mem_rd, mem_regwrite             destination and writeback flag in MEM
//   ex_md_start   a mul/div has just entered EX
//   ex_br_taken   branch or jump in EX resolved taken
//   fwd_a, fwd_b  operand selects: 00 regfile, 01 MEM result, 10 WB result
//   pc_we, ifid_we, idex_we   pipeline-register write enables
//   ifid_flush, idex_flush    load NOP / bubble into IF/ID, ID/EX
//   exmem_bubble  EX/MEM loads a bubble while the mul/div is incomplete
//   md_busy       mul/div FSM is in BUSY
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int RA_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            ex_md_start,
  input  logic            ex_br_taken,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_we,
  output logic            idex_flush,
  output logic            exmem_bubble,
  output logic            md_busy
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [3:0] CNT_INIT = 4'(MD_LAT - 2);

  md_state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use, md_stall;
  logic [1:0] fwd_a_next, fwd_b_next;

  // Register 0 is hard-wired zero, so it never counts as a producer.
  assign ex_hit_rs  = id_use_rs && ex_regwrite  && (ex_rd  != '0) && (ex_rd  == id_rs);
  assign ex_hit_rt  = id_use_rt && ex_regwrite  && (ex_rd  != '0) && (ex_rd  == id_rt);
  assign mem_hit_rs = id_use_rs && mem_regwrite && (mem_rd != '0) && (mem_rd == id_rs);
  assign mem_hit_rt = id_use_rt && mem_regwrite && (mem_rd != '0) && (mem_rd == id_rt);

  assign load_use = ex_memread && (ex_hit_rs || ex_hit_rt);

  // The start cycle already stalls; the last BUSY cycle (cnt==0) releases.
  assign md_stall = ((state == IDLE) && ex_md_start) || ((state == BUSY) && (cnt != 4'd0));

  // md_busy reflects the FSM state, including the releasing cycle.
  assign md_busy = (state == BUSY);

  // Selects are computed for the ID instruction and take effect once it is in
  // EX, so an EX producer will then sit in MEM and a MEM producer in WB.
  always_comb begin
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (ex_hit_rs)       fwd_a_next = 2'b01;
    else if (mem_hit_rs) fwd_a_next = 2'b10;
    if (ex_hit_rt)       fwd_b_next = 2'b01;
    else if (mem_hit_rt) fwd_b_next = 2'b10;
  end

  // Control priority: reset, then mul/div stall, then taken branch, then
  // load-use. A taken branch discards the ID instruction, so its load-use
  // hazard is moot and the PC must still load the target.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    if (!rst) begin
      if (md_stall) begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_bubble = 1'b1;
      end else if (ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Mul/div next-state logic; a new start is ignored while BUSY.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (ex_md_start) begin
          state_next = BUSY;
          cnt_next   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Forwarding selects follow the ID/EX register: cleared by a bubble and
  // frozen while ID/EX holds.
  always_ff @(posedge clk) begin
    if (rst || idex_flush) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (idex_we) begin
      fwd_a <= fwd_a_next;
      fwd_b <= fwd_b_next;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (MD_LAT=4, RA_W=5). Inputs change on
// the falling edge; every check happens 1 ns later, so combinational
// controls reflect the current inputs and fwd_a/fwd_b reflect the inputs of
// the previous cycle.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite;
  logic       ex_md_start, ex_br_taken;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_bubble, md_busy;

  int errors = 0;
  int checks = 0;

  // Control vectors: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_bubble, md_busy}
  localparam logic [6:0] NORM  = 7'b1101000;
  localparam logic [6:0] LU    = 7'b0001100;
  localparam logic [6:0] BR    = 7'b1111100;
  localparam logic [6:0] MDS0  = 7'b0000010;
  localparam logic [6:0] MDSB  = 7'b0000011;
  localparam logic [6:0] MDREL = 7'b1101001;

  pipe_hazard_ctrl #(.MD_LAT(4), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .ex_md_start(ex_md_start), .ex_br_taken(ex_br_taken),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble), .md_busy(md_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs at the falling edge and settle.
  task automatic applyStimulus(
    input logic r,
    input logic [4:0] rs, input logic urs,
    input logic [4:0] rt, input logic urt,
    input logic [4:0] erd, input logic erw, input logic emr,
    input logic [4:0] mrd, input logic mrw,
    input logic md, input logic br
  );
    @(negedge clk);
    rst = r;
    id_rs = rs; id_use_rs = urs;
    id_rt = rt; id_use_rt = urt;
    ex_rd = erd; ex_regwrite = erw; ex_memread = emr;
    mem_rd = mrd; mem_regwrite = mrw;
    ex_md_start = md; ex_br_taken = br;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_a,
                             input logic [1:0] exp_b, input logic [6:0] exp_ctl);
    logic [10:0] obs, expv;
    obs  = {fwd_a, fwd_b, pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_bubble, md_busy};
    expv = {exp_a, exp_b, exp_ctl};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0;
    ex_md_start = 0; ex_br_taken = 0;
    repeat (2) @(posedge clk);

    // Reset dominates a mul/div start.
    applyStimulus(1, 0,0, 0,0, 0,0,0, 0,0, 1,0);
    checkOutput("reset", 2'b00, 2'b00, NORM);

    // add r3 in EX, ID reads r3 as rs.
    applyStimulus(0, 3,1, 0,0, 3,1,0, 0,0, 0,0);
    checkOutput("ex_hit_cycle", 2'b00, 2'b00, NORM);
    // r3 now in MEM, ID still reads r3.
    applyStimulus(0, 3,1, 0,0, 0,0,0, 3,1, 0,0);
    checkOutput("fwd_a_mem", 2'b01, 2'b00, NORM);
    applyStimulus(0, 0,0, 0,0, 0,0,0, 0,0, 0,0);
    checkOutput("fwd_a_wb", 2'b10, 2'b00, NORM);
    applyStimulus(0, 0,0, 0,0, 0,0,0, 0,0, 0,0);
    checkOutput("fwd_idle", 2'b00, 2'b00, NORM);

    // EX and MEM both produce r7: EX wins for rt; rs matches but is unused.
    applyStimulus(0, 7,0, 7,1, 7,1,0, 7,1, 0,0);
    checkOutput("ex_mem_both", 2'b00, 2'b00, NORM);
    applyStimulus(0, 0,0, 0,0, 0,0,0, 0,0, 0,0);
    checkOutput("ex_beats_mem", 2'b00, 2'b01, NORM);

    // lw r5 in EX, ID reads r5 as rt: one-cycle stall.
    applyStimulus(0, 0,0, 5,1, 5,1,1, 0,0, 0,0);
    checkOutput("load_use_stall", 2'b00, 2'b00, LU);
    // Load now in MEM, bubble in EX: no second stall.
    applyStimulus(0, 0,0, 5,1, 0,0,0, 5,1, 0,0);
    checkOutput("load_use_after", 2'b00, 2'b00, NORM);
    // Load in EX but its rd is unused by ID: no stall.
    applyStimulus(0, 9,1, 6,0, 6,1,1, 0,0, 0,0);
    checkOutput("load_unused", 2'b00, 2'b10, NORM);
    applyStimulus(0, 0,0, 0,0, 0,0,0, 0,0, 0,0);
    checkOutput("after_unused", 2'b00, 2'b00, NORM);

    // Taken branch with concurrent load-use hit on both sources.
    applyStimulus(0, 5,1, 5,1, 5,1,1, 0,0, 0,1);
    checkOutput("branch_over_lu", 2'b00, 2'b00, BR);
    // Set up fwd_a=01 to observe holding during the mul/div stall.
    applyStimulus(0, 2,1, 0,0, 2,1,0, 0,0, 0,0);
    checkOutput("branch_flushed_fwd", 2'b00, 2'b00, NORM);

    // Mul/div start with a taken branch and a would-be rt hit: stall wins.
    applyStimulus(0, 0,0, 9,1, 9,1,0, 0,0, 1,1);
    checkOutput("md_start", 2'b01, 2'b00, MDS0);
    applyStimulus(0, 0,0, 9,1, 9,1,0, 0,0, 1,1);
    checkOutput("md_busy_1", 2'b01, 2'b00, MDSB);
    applyStimulus(0, 0,0, 9,1, 9,1,1, 0,0, 1,0);
    checkOutput("md_busy_2", 2'b01, 2'b00, MDSB);
    applyStimulus(0, 0,0, 0,0, 0,0,0, 0,0, 1,0);
    checkOutput("md_release", 2'b01, 2'b00, MDREL);
    applyStimulus(0, 0,0, 0,0, 0,0,0, 0,0, 0,0);
    checkOutput("md_done", 2'b00, 2'b00, NORM);

    // Reset pulse during BUSY.
    applyStimulus(0, 4,1, 0,0, 4,1,0, 0,0, 1,0);
    checkOutput("md_start_2", 2'b00, 2'b00, MDS0);
    applyStimulus(1, 0,1, 0,1, 0,1,0, 0,1, 0,0);
    checkOutput("rst_in_busy", 2'b00, 2'b00, MDREL);
    // Register 0 as producer never forwards.
    applyStimulus(0, 0,1, 0,1, 0,1,0, 0,1, 0,0);
    checkOutput("after_rst", 2'b00, 2'b00, NORM);
    applyStimulus(0, 0,0, 0,0, 0,0,0, 0,0, 0,0);
    checkOutput("reg0_no_fwd", 2'b00, 2'b00, NORM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
